// File: rtl/sw_conditioner.sv
// sw_conditioner: input-conditioning stage ahead of the platform switch PIOs.
//   Raw board switches (init, stop, 2-bit selector) are passed through a
//   SYNC_STAGES-deep synchroniser and a per-channel debounce counter, so the
//   pio_sw_*_external_connection exports only ever see clean, stable levels.
//
// Parameters:
//   SYNC_STAGES  synchroniser depth per channel, legal range 2..4
//   DB_CYCLES    cycles a new value must stay stable before acceptance, >= 2
//
// Ports:
//   clk_clk          in   system clock shared with the platform
//   reset_reset_n    in   synchronous reset, active low
//   sw_init_raw      in   raw init switch (asynchronous)
//   sw_stop_raw      in   raw stop switch (asynchronous)
//   sw_selector_raw  in   raw 2-bit selector (asynchronous)
//   sw_init_o        out  debounced init level
//   sw_stop_o        out  debounced stop level
//   sw_selector_o    out  debounced selector
//   sw_init_rise     out  1-cycle pulse after sw_init_o goes 0->1
//   sw_stop_rise     out  1-cycle pulse after sw_stop_o goes 0->1
//   sw_selector_chg  out  1-cycle pulse after sw_selector_o changes
//
// Build option:
//   SW_PULSE_EN  when defined, the three pulse outputs are generated; when
//                undefined they are tied to 0 and no pulse flops exist.

module sw_conditioner_channel #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_CYCLES   = 500000,
  parameter int unsigned W           = 1,
  parameter bit          RETARGET    = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] raw,
  output logic [W-1:0] level
);

  localparam int unsigned CNT_W = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [W-1:0]     sync [SYNC_STAGES];
  logic [W-1:0]     sync_q;
  logic [W-1:0]     prev;
  logic [W-1:0]     stable;
  logic [CNT_W-1:0] cnt;
  logic             retarget;

  assign sync_q = sync[SYNC_STAGES-1];
  assign level  = stable;

  // A multi-bit channel restarts qualification when it jumps from one pending
  // candidate to another. Leaving the stable value is not a restart: the
  // counter is already 0, so a fresh change keeps the nominal latency.
  assign retarget = RETARGET && (sync_q != prev) && (prev != stable);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync[i] <= '0;
      end
    end else begin
      sync[0] <= raw;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync[i] <= sync[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev   <= '0;
      stable <= '0;
      cnt    <= '0;
    end else begin
      prev <= sync_q;
      if (sync_q == stable) begin
        cnt <= '0;
      end else if (retarget) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= sync_q;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

module sw_conditioner #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_CYCLES   = 500000
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       sw_init_raw,
  input  logic       sw_stop_raw,
  input  logic [1:0] sw_selector_raw,
  output logic       sw_init_o,
  output logic       sw_stop_o,
  output logic [1:0] sw_selector_o,
  output logic       sw_init_rise,
  output logic       sw_stop_rise,
  output logic       sw_selector_chg
);

  sw_conditioner_channel #(
    .SYNC_STAGES (SYNC_STAGES),
    .DB_CYCLES   (DB_CYCLES),
    .W           (1),
    .RETARGET    (1'b0)
  ) u_init (
    .clk   (clk_clk),
    .rst_n (reset_reset_n),
    .raw   (sw_init_raw),
    .level (sw_init_o)
  );

  sw_conditioner_channel #(
    .SYNC_STAGES (SYNC_STAGES),
    .DB_CYCLES   (DB_CYCLES),
    .W           (1),
    .RETARGET    (1'b0)
  ) u_stop (
    .clk   (clk_clk),
    .rst_n (reset_reset_n),
    .raw   (sw_stop_raw),
    .level (sw_stop_o)
  );

  // Selector is qualified as one vector so software never sees a half-moved
  // value while the two switches settle at different times.
  sw_conditioner_channel #(
    .SYNC_STAGES (SYNC_STAGES),
    .DB_CYCLES   (DB_CYCLES),
    .W           (2),
    .RETARGET    (1'b1)
  ) u_sel (
    .clk   (clk_clk),
    .rst_n (reset_reset_n),
    .raw   (sw_selector_raw),
    .level (sw_selector_o)
  );

`ifdef SW_PULSE_EN
  logic       init_d;
  logic       stop_d;
  logic [1:0] sel_d;
  logic       init_rise_q;
  logic       stop_rise_q;
  logic       sel_chg_q;

  // Delayed copies are cleared with the stable registers, so leaving reset
  // never looks like an edge.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      init_d      <= 1'b0;
      stop_d      <= 1'b0;
      sel_d       <= '0;
      init_rise_q <= 1'b0;
      stop_rise_q <= 1'b0;
      sel_chg_q   <= 1'b0;
    end else begin
      init_d      <= sw_init_o;
      stop_d      <= sw_stop_o;
      sel_d       <= sw_selector_o;
      init_rise_q <= sw_init_o & ~init_d;
      stop_rise_q <= sw_stop_o & ~stop_d;
      sel_chg_q   <= (sw_selector_o != sel_d);
    end
  end

  assign sw_init_rise    = init_rise_q;
  assign sw_stop_rise    = stop_rise_q;
  assign sw_selector_chg = sel_chg_q;
`else
  assign sw_init_rise    = 1'b0;
  assign sw_stop_rise    = 1'b0;
  assign sw_selector_chg = 1'b0;
`endif

endmodule
